// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - size_e      : store width encoding carried on write_size
//   - state_e     : responder FSM states
//   - req_t       : one captured request (type, address, data, size)
//   - byte_enable : lane mask for a store, bit 3 = bits [31:24] (big-endian)
//   - lane_data   : replicates right-justified store data onto every lane
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        size_e       size;
    } req_t;

    // An empty mask marks a store that cannot be performed: the reserved
    // size, or a halfword/word that is not naturally aligned.
    function automatic logic [3:0] byte_enable(size_e size, logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b1000 >> a;
            SZ_HALF: return a[0] ? 4'b0000 : (a[1] ? 4'b0011 : 4'b1100);
            SZ_WORD: return (a == 2'b00) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    // With the data copied onto every lane, the enable mask alone selects
    // which bytes land, so no per-offset shifting is needed.
    function automatic logic [31:0] lane_data(size_e size, logic [31:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus.
//   master (pipeline) drives : MemRead, MemWrite, address, data_write, write_size
//   slave (responder) drives : data_read, busy, addr_error
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] data_write;
    logic [1:0]  write_size;
    logic [31:0] data_read;
    logic        busy;
    logic        addr_error;

    modport master (
        output MemRead, MemWrite, address, data_write, write_size,
        input  data_read, busy, addr_error
    );

    modport slave (
        input  MemRead, MemWrite, address, data_write, write_size,
        output data_read, busy, addr_error
    );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with per-byte write enables and an asynchronous read.
//   CLK     : write clock
//   we_i    : commit write this edge
//   waddr_i : word index to write;  be_i : lane mask (bit 3 = [31:24])
//   wdata_i : lane-replicated write data
//   raddr_i : word index to read;   rdata_o : combinational read data
module dmem_array #(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic                     CLK,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [3:0]               be_i,
    input  logic [31:0]              wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem_q [DEPTH];

    // NOTE: storage has no reset branch; a memory cannot be cleared in one
    // cycle and its contents must survive a pipeline reset.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage. Services one read or write after
// LATENCY cycles, freezing the pipeline through busy meanwhile.
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : slave side of dmem_responder_if (requests in; data_read,
//                busy and addr_error out)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic             CLK,
    input  logic             RESET,
    dmem_responder_if.slave  bus
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

    req_t            in_req;
    req_t            cur_req;   // request whose address drives the read port
    req_t            wr_req;    // request whose data drives the write port
    logic            err;
    logic            we;
    logic [31:0]     rdata;

    function automatic logic request_error(req_t r);
        if (!(r.rd || r.wr))                                  return 1'b0;
        if (r.rd && r.wr)                                     return 1'b1;
        if ({1'b0, r.addr} >= ADDR_LIMIT)                     return 1'b1;
        if (r.wr && byte_enable(r.size, r.addr[1:0]) == 4'b0) return 1'b1;
        return 1'b0;
    endfunction

    always_comb begin
        in_req.rd    = bus.MemRead;
        in_req.wr    = bus.MemWrite;
        in_req.addr  = bus.address;
        in_req.wdata = bus.data_write;
        in_req.size  = size_e'(bus.write_size);
    end

    assign err = request_error(cur_req);

    dmem_array #(.DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_array (
        .CLK     (CLK),
        .we_i    (we),
        .waddr_i (wr_req.addr[AW+1:2]),
        .be_i    (byte_enable(wr_req.size, wr_req.addr[1:0])),
        .wdata_i (lane_data(wr_req.size, wr_req.wdata)),
        .raddr_i (cur_req.addr[AW+1:2]),
        .rdata_o (rdata)
    );

    if (LATENCY == 0) begin : g_single
        // Single-cycle: everything comes straight from the live request; a
        // read of the word being written sees the old contents.
        assign cur_req        = in_req;
        assign wr_req         = in_req;
        assign we             = in_req.wr && !err && !RESET;
        assign bus.busy       = 1'b0;
        assign bus.data_read  = err ? 32'h0 : rdata;
        assign bus.addr_error = err;
    end else begin : g_fsm
        localparam logic [3:0] CNT_INIT    = 4'(LATENCY - 1);
        localparam state_e     FIRST_STATE = (LATENCY == 1) ? DONE : WAIT;

        state_e      state_q, state_d;
        logic [3:0]  cnt_q, cnt_d;
        req_t        req_q, req_d;
        logic [31:0] dr_q, dr_d;
        logic        busy, addr_err, commit;

        // In IDLE the request has not been captured yet.
        assign cur_req = (state_q == IDLE) ? in_req : req_q;
        assign wr_req  = req_q;
        assign we      = commit && !RESET;

        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            req_d    = req_q;
            dr_d     = dr_q;
            busy     = 1'b0;
            addr_err = 1'b0;
            commit   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_req.rd || in_req.wr) begin
                        busy    = 1'b1;
                        req_d   = in_req;
                        cnt_d   = CNT_INIT;
                        state_d = FIRST_STATE;
                    end
                end
                WAIT: begin
                    busy = 1'b1;
                    // Counter holds the WAIT cycles still to run.
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    addr_err = err;
                    commit   = req_q.wr && !err;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // data_read is captured once, on entry to DONE, then held.
            if (state_d == DONE && state_q != DONE) dr_d = err ? 32'h0 : rdata;
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                state_q <= IDLE;
                cnt_q   <= 4'd0;
                req_q   <= '0;
                dr_q    <= 32'h0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                req_q   <= req_d;
                dr_q    <= dr_d;
            end
        end

        assign bus.busy       = busy;
        assign bus.data_read  = dr_q;
        assign bus.addr_error = addr_err;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance, each fed
// directed then random requests. Expected responses come from a byte-addressed
// big-endian memory model and are queued; per-instance monitors pop and compare.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int LIMIT = DEPTH * 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk;   // data known (all four bytes written before)
    } exp_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    dmem_responder_if if2 ();
    dmem_responder_if if0 ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2), .INIT_FILE("")) dut2 (
        .CLK(CLK), .RESET(RESET), .bus(if2.slave));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0), .INIT_FILE("")) dut0 (
        .CLK(CLK), .RESET(RESET), .bus(if0.slave));

    int   checks = 0;
    int   errors = 0;
    exp_t q2[$];
    exp_t q0[$];
    logic [7:0] mem   [2][LIMIT];
    bit         known [2][LIMIT];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: memory as bytes, big-endian, stores of 1/2/4 bytes.
    task automatic model(int id, bit rd, bit wr, logic [31:0] addr,
                         logic [31:0] wd, logic [1:0] sz, output exp_t e);
        int n;
        int base;
        e.err = (rd && wr) || (addr >= LIMIT) ||
                (wr && (sz == 2'd3 || (sz == 2'd1 && addr % 2 != 0) ||
                        (sz == 2'd2 && addr % 4 != 0)));
        e.data = 32'h0;
        e.chk  = 1'b1;
        if (!e.err) begin
            base   = int'(addr) - int'(addr) % 4;
            e.data = {mem[id][base], mem[id][base+1], mem[id][base+2], mem[id][base+3]};
            e.chk  = known[id][base] && known[id][base+1] && known[id][base+2] && known[id][base+3];
            if (wr) begin
                n = 1 << sz;
                for (int k = 0; k < n; k++) begin
                    mem[id][int'(addr) + k]   = 8'(wd >> (8 * (n - 1 - k)));
                    known[id][int'(addr) + k] = 1'b1;
                end
            end
        end
    endtask

    task automatic issue2(bit rd, bit wr, logic [31:0] addr, logic [31:0] wd, logic [1:0] sz);
        exp_t e;
        int   n;
        @(posedge CLK); #1;
        if2.MemRead = rd; if2.MemWrite = wr; if2.address = addr;
        if2.data_write = wd; if2.write_size = sz;
        model(0, rd, wr, addr, wd, sz, e);
        q2.push_back(e);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (if2.busy === 1'b1 && n < 40);
        check("busy_release", if2.busy, 1'b0);
    endtask

    task automatic idle2();
        @(posedge CLK); #1;
        if2.MemRead = 1'b0; if2.MemWrite = 1'b0;
    endtask

    task automatic issue0(bit rd, bit wr, logic [31:0] addr, logic [31:0] wd, logic [1:0] sz);
        exp_t e;
        @(posedge CLK); #1;
        if0.MemRead = rd; if0.MemWrite = wr; if0.address = addr;
        if0.data_write = wd; if0.write_size = sz;
        model(1, rd, wr, addr, wd, sz, e);
        q0.push_back(e);
    endtask

    task automatic idle0();
        @(posedge CLK); #1;
        if0.MemRead = 1'b0; if0.MemWrite = 1'b0;
    endtask

    task automatic rand_req(output bit rd, output bit wr, output logic [31:0] addr,
                            output logic [31:0] wd, output logic [1:0] sz);
        int k;
        k    = $urandom_range(0, 9);
        rd   = (k <= 3) || (k == 9);
        wr   = (k >= 4);
        sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(LIMIT, LIMIT + 15))
                                           : 32'($urandom_range(0, LIMIT - 1));
        if ($urandom_range(0, 3) != 0 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 32'd1);
        wd   = $urandom;
    endtask

    // Monitor, LATENCY=2: a busy run followed by a non-busy cycle is DONE.
    initial begin : mon2
        int          busy_cnt = 0;
        bit          abort    = 1'b0;
        logic [31:0] last_dr  = 32'h0;
        exp_t        e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                abort    = 1'b1;
                busy_cnt = 0;
            end else if (abort) begin
                abort = 1'b0;
                check("reset_busy", if2.busy, 1'b0);
                check("reset_data", if2.data_read, 32'h0);
                check("reset_err", if2.addr_error, 1'b0);
                last_dr = 32'h0;
            end else if (if2.busy) begin
                busy_cnt++;
                check("hold_data_busy", if2.data_read, last_dr);
            end else if (busy_cnt > 0) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got a completion, expected none");
                end else begin
                    e = q2.pop_front();
                    check("done_err", if2.addr_error, e.err);
                    if (e.chk) check("done_data", if2.data_read, e.data);
                    check("busy_cycles", busy_cnt, 2);
                    last_dr = if2.data_read;
                end
                busy_cnt = 0;
            end else begin
                check("idle_err", if2.addr_error, 1'b0);
                check("hold_data_idle", if2.data_read, last_dr);
            end
        end
    end

    // Monitor, LATENCY=0: every request cycle is its own completion.
    initial begin : mon0
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                check("l0_busy", if0.busy, 1'b0);
                if (if0.MemRead || if0.MemWrite) begin
                    if (q0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL l0_unexpected: got a request cycle, expected none");
                    end else begin
                        e = q0.pop_front();
                        check("l0_err", if0.addr_error, e.err);
                        if (e.chk) check("l0_data", if0.data_read, e.data);
                    end
                end else begin
                    check("l0_idle_err", if0.addr_error, 1'b0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit          rd, wr;
        logic [31:0] addr, wd;
        logic [1:0]  sz;
        if2.MemRead = 1'b0; if2.MemWrite = 1'b0; if2.address = '0;
        if2.data_write = '0; if2.write_size = 2'd2;
        if0.MemRead = 1'b0; if0.MemWrite = 1'b0; if0.address = '0;
        if0.data_write = '0; if0.write_size = 2'd2;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        // ---- LATENCY = 2 ----
        for (int i = 0; i < DEPTH; i++) issue2(0, 1, 32'(i * 4), 32'h5A5A_0000 | 32'(i), 2'd2);
        issue2(0, 1, 32'h10, 32'hDEAD_BEEF, 2'd2);
        issue2(1, 0, 32'h10, 32'h0, 2'd0);
        issue2(0, 1, 32'h10, 32'h1122_3344, 2'd2);
        issue2(0, 1, 32'h11, 32'h1234_56AA, 2'd0);
        issue2(1, 0, 32'h10, 32'h0, 2'd2);
        issue2(0, 1, 32'h12, 32'hFFFF_5566, 2'd1);
        issue2(1, 0, 32'h10, 32'h0, 2'd2);
        issue2(0, 1, 32'h13, 32'h0000_7788, 2'd1);
        issue2(1, 0, 32'(LIMIT), 32'h0, 2'd2);
        issue2(1, 0, 32'h10, 32'h0, 2'd2);
        issue2(1, 1, 32'h20, 32'h1234_5678, 2'd2);
        issue2(1, 0, 32'h20, 32'h0, 2'd2);
        issue2(0, 1, 32'h24, 32'h9999_9999, 2'd3);
        issue2(0, 1, 32'h26, 32'h8888_8888, 2'd2);
        issue2(1, 0, 32'h24, 32'h0, 2'd2);
        issue2(0, 1, 32'(LIMIT - 4), 32'hA5A5_5A5A, 2'd2);
        issue2(1, 0, 32'(LIMIT - 1), 32'h0, 2'd0);
        idle2();

        // Reset during WAIT of a write: aborted, nothing committed.
        @(posedge CLK); #1;
        if2.MemWrite = 1'b1; if2.address = 32'h30;
        if2.data_write = 32'hCAFE_BABE; if2.write_size = 2'd2;
        @(posedge CLK); #1;
        RESET = 1'b1; if2.MemWrite = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        issue2(1, 0, 32'h30, 32'h0, 2'd2);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle2();
            rand_req(rd, wr, addr, wd, sz);
            issue2(rd, wr, addr, wd, sz);
        end
        idle2();

        // ---- LATENCY = 0 ----
        for (int i = 0; i < DEPTH; i++) issue0(0, 1, 32'(i * 4), 32'hC3C3_0000 | 32'(i), 2'd2);
        issue0(0, 1, 32'h40, 32'h0000_0001, 2'd2);
        issue0(1, 0, 32'h40, 32'h0, 2'd2);
        issue0(0, 1, 32'h41, 32'h0000_00EE, 2'd0);
        issue0(1, 0, 32'h41, 32'h0, 2'd0);
        issue0(1, 1, 32'h44, 32'hFFFF_FFFF, 2'd2);
        issue0(1, 0, 32'(LIMIT + 4), 32'h0, 2'd2);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle0();
            rand_req(rd, wr, addr, wd, sz);
            issue0(rd, wr, addr, wd, sz);
        end
        idle0();

        repeat (4) @(negedge CLK);
        check("q2_drained", 32'(q2.size()), 32'd0);
        check("q0_drained", 32'(q0.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
